key_event_scheduler: RTL and testbench
======================================

# key_event_scheduler

Turns the debounced `pressed` levels of up to NUM_KEYS key debouncers into a single stream of timed key events: press, release, long-press and auto-repeat. Per-key timing state machines feed a one-deep pending slot per key. A round-robin arbiter serialises the slots onto one valid/ready event port. The block sits between the key debounce instances and the UI/register-control logic that consumes key events.

## Interface
- `NUM_KEYS`, 4: number of keys, 1..16.
- `CLK_FREQ`, 50_000_000: clk frequency in Hz; the internal 1 ms tick divides by CLK_FREQ/1000.
- `LONG_MS`, 1000: hold time before a LONG event, 1..65535.
- `REPEAT_MS`, 200: period of REPEAT events after LONG, 1..65535.

Ports:
- `clk`  in  1  single system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `key_pressed`  in  NUM_KEYS  debounced key levels, 1 = pressed, synchronous to clk.
- `evt_valid`  out  1  event available.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_key`  out  max(1,$clog2(NUM_KEYS))  index of the key.
- `evt_type`  out  2  0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- `evt_lost`  out  1  one-cycle pulse when a pending event is overwritten before it is granted.

## Operation
- Tick generator:
  - counter runs 0..CLK_FREQ/1000-1.
  - `tick` is high for one cycle at the terminal count.
  - The counter runs free after reset.
- Per key: a registered copy `key_prev` and a FSM with states IDLE, HELD, RPT, plus a 16-bit ms counter `ms_cnt`.
  - IDLE, rising edge (key_pressed=1, key_prev=0): post PRESS, set ms_cnt=0, go to HELD.
  - HELD, tick: ms_cnt+1. When the incremented value equals LONG_MS: post LONG, set ms_cnt=0, go to RPT.
  - RPT, tick: ms_cnt+1. When it equals REPEAT_MS: post REPEAT, set ms_cnt=0, stay in RPT.
  - HELD or RPT, falling edge: post RELEASE, go to IDLE. The release has priority over a tick-driven post in the same cycle.
- Pending slot, per key: `pend_v` plus a 2-bit type.
  - Posting writes the slot.
  - Posting while `pend_v`=1 and the slot is not being granted that cycle overwrites it and pulses `evt_lost`.
  - Grant and post in the same cycle: the granted event leaves, the new event occupies the slot, no loss.
- Arbiter:
  - The output register loads when `evt_valid`=0 or (`evt_valid` && `evt_ready`).
  - It takes the first key with `pend_v`=1, searching from last_grant+1 modulo NUM_KEYS.
  - Loading clears that key's `pend_v`.
  - If nothing is pending, `evt_valid` drops after a handshake.
- Handshake:
  - `evt_key`/`evt_type` stay stable while `evt_valid`=1 and `evt_ready`=0.
  - Back-to-back transfers are allowed, one per cycle.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_key`=0, `evt_type`=0, `evt_lost`=0.
  - All FSMs in IDLE; `key_prev`=0.
  - All `pend_v`=0, ms_cnt=0, tick counter=0.
  - last_grant=NUM_KEYS-1, so key 0 is searched first.
- Latency, with the output register free:
  - `key_pressed` changes before edge k; the slot is written at edge k.
  - `evt_valid`=1 after edge k+1.
- LONG is posted at the LONG_MS-th tick after the press edge. Real hold time is LONG_MS-1..LONG_MS ms because the tick phase is free-running.
- Key held at reset release (`key_pressed`=1 at the first edge): this is a rising edge, so PRESS is posted.
- Reset asserted mid-transfer clears `evt_valid` immediately (asynchronous); pending events are discarded.
- `ms_cnt` never wraps: it is reset at the LONG_MS/REPEAT_MS match, and both parameters are ≤65535.

## Structure
- Package `key_evt_pkg`: 2-bit event-type constants EVT_PRESS/EVT_RELEASE/EVT_LONG/EVT_REPEAT and FSM state encodings.
- Sub-module `key_evt_fsm`:
  - one instance per key, holding key_prev, the FSM, ms_cnt and the pending slot.
  - inputs: tick, grant.
  - outputs: pend_v, pend_type, lost.
- Top level holds the tick divider, the round-robin arbiter, the output register and the OR of the lost flags.

## Test plan
Common setup: CLK_FREQ=10_000 (tick every 10 clk), LONG_MS=5, REPEAT_MS=2, NUM_KEYS=4, `evt_ready`=1 unless stated.
- Key 1 rises, holds 3 ms, falls -> PRESS(key1) 2 cycles after the rise, then RELEASE(key1); no LONG, `evt_lost`=0.
- Key 2 held 10 ms -> PRESS, LONG at the 5th tick, REPEAT at the 7th and 9th ticks, RELEASE on the fall.
- Keys 0-3 rise in the same cycle -> PRESS for keys 0,1,2,3 on four consecutive cycles. A second simultaneous release burst is granted starting after last_grant=3, i.e. key 0 first.
- `evt_ready`=0 for 100 cycles while key 0 toggles press/release twice -> `evt_valid` and its payload stay stable. `evt_lost` pulses for each overwrite. After `evt_ready`=1 the latest pending event (RELEASE) is delivered.
- Reset asserted while `evt_valid`=1 and a key is held -> outputs are 0 immediately. After release with the key still held, a fresh PRESS is delivered.

Source files
------------

// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared event-type and key-state encodings for the key event scheduler
//
// Purpose: 2-bit event codes carried on evt_type and the per-key timing FSM states.
package key_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_RPT  = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_evt_fsm.sv
// rtl/key_evt_fsm.sv - per-key press/long/repeat timing FSM with a one-deep pending event slot
//
// Purpose: detects edges on one debounced key level, times the hold in ms ticks
// and posts PRESS/RELEASE/LONG/REPEAT into a single pending slot.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   key_pressed   debounced key level (1 = pressed)
//   tick          one-cycle 1 ms strobe
//   grant         arbiter is taking this key's pending event this cycle
//   pend_v        pending slot holds an event
//   pend_type     event code of the pending slot
//   lost          one-cycle pulse: a pending event was overwritten before grant
module key_evt_fsm #(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_pressed,
  input  logic       tick,
  input  logic       grant,
  output logic       pend_v,
  output logic [1:0] pend_type,
  output logic       lost
);
  import key_evt_pkg::*;

  localparam logic [15:0] LONG_V = 16'(LONG_MS);
  localparam logic [15:0] REP_V  = 16'(REPEAT_MS);

  key_state_e  state;
  logic        key_prev;
  logic [15:0] ms_cnt;
  logic [15:0] ms_nxt;
  logic        rise;
  logic        fall;
  logic        post;
  logic [1:0]  post_type;

  assign rise   = key_pressed & ~key_prev;
  assign fall   = ~key_pressed & key_prev;
  assign ms_nxt = ms_cnt + 16'd1;

  // Release is checked before the tick so it wins over a LONG/REPEAT in the same cycle.
  always_comb begin
    post      = 1'b0;
    post_type = EVT_PRESS;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          post      = 1'b1;
          post_type = EVT_PRESS;
        end
      end
      ST_HELD: begin
        if (fall) begin
          post      = 1'b1;
          post_type = EVT_RELEASE;
        end else if (tick && ms_nxt == LONG_V) begin
          post      = 1'b1;
          post_type = EVT_LONG;
        end
      end
      ST_RPT: begin
        if (fall) begin
          post      = 1'b1;
          post_type = EVT_RELEASE;
        end else if (tick && ms_nxt == REP_V) begin
          post      = 1'b1;
          post_type = EVT_REPEAT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      key_prev  <= 1'b0;
      ms_cnt    <= 16'd0;
      pend_v    <= 1'b0;
      pend_type <= EVT_PRESS;
      lost      <= 1'b0;
    end else begin
      key_prev <= key_pressed;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            ms_cnt <= 16'd0;
            state  <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (fall) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (ms_nxt == LONG_V) begin
              ms_cnt <= 16'd0;
              state  <= ST_RPT;
            end else begin
              ms_cnt <= ms_nxt;
            end
          end
        end
        ST_RPT: begin
          if (fall) begin
            state <= ST_IDLE;
          end else if (tick) begin
            ms_cnt <= (ms_nxt == REP_V) ? 16'd0 : ms_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A post in the grant cycle refills the slot the arbiter is emptying: no loss.
      lost <= post & pend_v & ~grant;
      if (post) begin
        pend_v    <= 1'b1;
        pend_type <= post_type;
      end else if (grant) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// rtl/key_event_scheduler.sv - serialises timed key events from NUM_KEYS keys onto one valid/ready port
//
// Purpose: 1 ms tick divider, one key_evt_fsm per key, round-robin arbiter and
// registered event output.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   key_pressed[N]        debounced key levels
//   evt_valid/evt_ready   event handshake
//   evt_key               index of the key for the presented event
//   evt_type              0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   evt_lost              one-cycle pulse when any pending event is overwritten
module key_event_scheduler #(
  parameter int NUM_KEYS  = 4,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_pressed,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_key,
  output logic [1:0]          evt_type,
  output logic                evt_lost
);
  import key_evt_pkg::*;

  localparam int DIV = CLK_FREQ / 1000;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] pend_v;
  logic [1:0]          pend_type [NUM_KEYS];
  logic [NUM_KEYS-1:0] lost_vec;
  logic [NUM_KEYS-1:0] grant;
  logic [KW-1:0]       last_grant;
  logic [KW-1:0]       sel;
  logic                found;
  logic                load;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_evt_fsm #(
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_fsm (
      .clk         (clk),
      .resetn      (resetn),
      .key_pressed (key_pressed[i]),
      .tick        (tick),
      .grant       (grant[i]),
      .pend_v      (pend_v[i]),
      .pend_type   (pend_type[i]),
      .lost        (lost_vec[i])
    );
  end

  assign evt_lost = |lost_vec;
  assign load     = ~evt_valid | evt_ready;

  // Round-robin: first pending key starting one past the last grant, wrapping.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    sel   = '0;
    for (int off = 1; off <= NUM_KEYS; off++) begin
      j = int'(last_grant) + off;
      if (j >= NUM_KEYS) j = j - NUM_KEYS;
      if (!found && pend_v[KW'(j)]) begin
        found = 1'b1;
        sel   = KW'(j);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && found) grant[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      evt_valid  <= 1'b0;
      evt_key    <= '0;
      evt_type   <= EVT_PRESS;
      last_grant <= KW'(NUM_KEYS - 1);
    end else if (load) begin
      if (found) begin
        evt_valid  <= 1'b1;
        evt_key    <= sel;
        evt_type   <= pend_type[sel];
        last_grant <= sel;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// tb/tb_key_event_scheduler.sv - self-checking bench for key_event_scheduler
module tb_key_event_scheduler;
  localparam int N     = 4;
  localparam int TICK  = 10;
  localparam int LONG  = 5;
  localparam int REP   = 2;
  localparam int T_PRESS = 0;
  localparam int T_REL   = 1;
  localparam int T_LONG  = 2;
  localparam int T_REP   = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] key_pressed = 4'h0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       evt_lost;

  int errors = 0;
  int checks = 0;
  int edge_n;
  int lost_cnt = 0;
  int obs_code[$];
  int obs_edge[$];
  int exp_code[$];
  int exp_edge[$];

  key_event_scheduler #(
    .NUM_KEYS  (N),
    .CLK_FREQ  (TICK * 1000),
    .LONG_MS   (LONG),
    .REPEAT_MS (REP)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_pressed (key_pressed),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_type    (evt_type),
    .evt_lost    (evt_lost)
  );

  always #5 clk = ~clk;

  // Number of clock edges seen by the design since reset was released.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) edge_n <= 0;
    else         edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      obs_code.push_back(int'(evt_key) * 4 + int'(evt_type));
      obs_edge.push_back(edge_n);
    end
  end

  always @(negedge clk) begin
    if (resetn && evt_lost) lost_cnt <= lost_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    obs_code.delete();
    obs_edge.delete();
    exp_code.delete();
    exp_edge.delete();
  endtask

  // Reference: a key pressed (first seen) at edge p and released at edge r.
  // Ticks happen at edges that are multiples of TICK; the n-th tick strictly
  // inside (p, r) gives LONG at n==LONG and REPEAT every REP ticks after.
  task automatic model_hold(input int k, input int p, input int r);
    int n;
    n = 0;
    exp_code.push_back(k * 4 + T_PRESS);
    exp_edge.push_back(p);
    for (int t = p + 1; t < r; t++) begin
      if (t % TICK == 0) begin
        n++;
        if (n == LONG) begin
          exp_code.push_back(k * 4 + T_LONG);
          exp_edge.push_back(t);
        end else if (n > LONG && (n - LONG) % REP == 0) begin
          exp_code.push_back(k * 4 + T_REP);
          exp_edge.push_back(t);
        end
      end
    end
    exp_code.push_back(k * 4 + T_REL);
    exp_edge.push_back(r);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    key_pressed = 4'h0;
    evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", evt_valid); end
    checks++;
    if (evt_key !== 2'd0) begin errors++; $display("FAIL reset_key: got %0d expected 0", evt_key); end
    checks++;
    if (evt_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %0d expected 0", evt_type); end
    checks++;
    if (evt_lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %0b expected 0", evt_lost); end
    do_reset();
  endtask

  task automatic test_press_release();
    int p, r, lost0;
    clear_all();
    lost0 = lost_cnt;
    step();
    key_pressed[1] = 1'b1;
    p = edge_n + 1;
    step();
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL pr_early: evt_valid=%0b expected 0", evt_valid); end
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_key !== 2'd1 || evt_type !== 2'(T_PRESS)) begin
      errors++;
      $display("FAIL pr_press: valid=%0b key=%0d type=%0d expected 1 1 %0d", evt_valid, evt_key, evt_type, T_PRESS);
    end
    repeat (28) step();
    key_pressed[1] = 1'b0;
    r = edge_n + 1;
    repeat (5) step();
    model_hold(1, p, r);
    checks++;
    if (obs_code.size() != exp_code.size()) begin
      errors++;
      $display("FAIL pr_count: got %0d events expected %0d", obs_code.size(), exp_code.size());
    end
    for (int i = 0; i < exp_code.size() && i < obs_code.size(); i++) begin
      checks++;
      if (obs_code[i] != exp_code[i] || obs_edge[i] != exp_edge[i] + 1) begin
        errors++;
        $display("FAIL pr_event%0d: code=%0d edge=%0d expected code=%0d edge=%0d", i, obs_code[i], obs_edge[i], exp_code[i], exp_edge[i] + 1);
      end
    end
    checks++;
    if (lost_cnt - lost0 != 0) begin errors++; $display("FAIL pr_lost: got %0d expected 0", lost_cnt - lost0); end
  endtask

  task automatic test_long_repeat();
    int p, r, nrep, nlong;
    clear_all();
    step();
    key_pressed[2] = 1'b1;
    p = edge_n + 1;
    repeat (100) step();
    key_pressed[2] = 1'b0;
    r = edge_n + 1;
    repeat (6) step();
    model_hold(2, p, r);
    checks++;
    if (obs_code.size() != exp_code.size()) begin
      errors++;
      $display("FAIL lr_count: got %0d events expected %0d", obs_code.size(), exp_code.size());
    end
    for (int i = 0; i < exp_code.size() && i < obs_code.size(); i++) begin
      checks++;
      if (obs_code[i] != exp_code[i] || obs_edge[i] != exp_edge[i] + 1) begin
        errors++;
        $display("FAIL lr_event%0d: code=%0d edge=%0d expected code=%0d edge=%0d", i, obs_code[i], obs_edge[i], exp_code[i], exp_edge[i] + 1);
      end
    end
    nrep = 0;
    nlong = 0;
    foreach (obs_code[i]) begin
      if (obs_code[i] == 2 * 4 + T_REP)  nrep++;
      if (obs_code[i] == 2 * 4 + T_LONG) nlong++;
    end
    checks++;
    if (nlong != 1 || nrep != 2) begin
      errors++;
      $display("FAIL lr_kinds: long=%0d repeat=%0d expected 1 2", nlong, nrep);
    end
  endtask

  task automatic test_simultaneous();
    int p, r;
    do_reset();
    clear_all();
    key_pressed = 4'hF;
    p = edge_n + 1;
    repeat (20) step();
    key_pressed = 4'h0;
    r = edge_n + 1;
    repeat (6) step();
    checks++;
    if (obs_code.size() != 8) begin errors++; $display("FAIL sim_count: got %0d events expected 8", obs_code.size()); end
    for (int k = 0; k < N && obs_code.size() == 8; k++) begin
      checks++;
      if (obs_code[k] != k * 4 + T_PRESS || obs_edge[k] != p + 1 + k) begin
        errors++;
        $display("FAIL sim_press%0d: code=%0d edge=%0d expected code=%0d edge=%0d", k, obs_code[k], obs_edge[k], k * 4 + T_PRESS, p + 1 + k);
      end
      checks++;
      if (obs_code[4 + k] != k * 4 + T_REL || obs_edge[4 + k] != r + 1 + k) begin
        errors++;
        $display("FAIL sim_rel%0d: code=%0d edge=%0d expected code=%0d edge=%0d", k, obs_code[4 + k], obs_edge[4 + k], k * 4 + T_REL, r + 1 + k);
      end
    end
  endtask

  task automatic test_backpressure();
    int lost0, bad;
    clear_all();
    lost0 = lost_cnt;
    bad = 0;
    evt_ready = 1'b0;
    step();
    key_pressed[0] = 1'b1;
    repeat (3) step();
    checks++;
    if (evt_valid !== 1'b1 || evt_key !== 2'd0 || evt_type !== 2'(T_PRESS)) begin
      errors++;
      $display("FAIL bp_first: valid=%0b key=%0d type=%0d expected 1 0 %0d", evt_valid, evt_key, evt_type, T_PRESS);
    end
    for (int c = 0; c < 97; c++) begin
      if (c == 7)  key_pressed[0] = 1'b0;
      if (c == 17) key_pressed[0] = 1'b1;
      if (c == 27) key_pressed[0] = 1'b0;
      step();
      if (evt_valid !== 1'b1 || evt_key !== 2'd0 || evt_type !== 2'(T_PRESS)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles expected 0", bad); end
    checks++;
    if (lost_cnt - lost0 != 2) begin errors++; $display("FAIL bp_lost: got %0d pulses expected 2", lost_cnt - lost0); end
    evt_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (obs_code.size() != 2) begin
      errors++;
      $display("FAIL bp_count: got %0d events expected 2", obs_code.size());
    end else if (obs_code[0] != T_PRESS || obs_code[1] != T_REL) begin
      errors++;
      $display("FAIL bp_order: got codes %0d,%0d expected %0d,%0d", obs_code[0], obs_code[1], T_PRESS, T_REL);
    end
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: evt_valid=%0b expected 0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    int waited, p, r;
    evt_ready = 1'b0;
    step();
    key_pressed[3] = 1'b1;
    waited = 0;
    while (evt_valid !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    checks++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL rm_wait: evt_valid=%0b expected 1 within 10 cycles", evt_valid); end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_key !== 2'd0 || evt_type !== 2'd0 || evt_lost !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: valid=%0b key=%0d type=%0d lost=%0b expected 0 0 0 0", evt_valid, evt_key, evt_type, evt_lost);
    end
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_all();
    resetn = 1'b1;
    p = edge_n + 1;
    repeat (8) step();
    key_pressed[3] = 1'b0;
    r = edge_n + 1;
    repeat (4) step();
    model_hold(3, p, r);
    checks++;
    if (obs_code.size() != exp_code.size()) begin
      errors++;
      $display("FAIL rm_count: got %0d events expected %0d", obs_code.size(), exp_code.size());
    end
    for (int i = 0; i < exp_code.size() && i < obs_code.size(); i++) begin
      checks++;
      if (obs_code[i] != exp_code[i] || obs_edge[i] != exp_edge[i] + 1) begin
        errors++;
        $display("FAIL rm_event%0d: code=%0d edge=%0d expected code=%0d edge=%0d", i, obs_code[i], obs_edge[i], exp_code[i], exp_edge[i] + 1);
      end
    end
  endtask

  // Random press/release on all keys, toggling only mid-way between ticks so
  // every burst of posts drains before the next one and nothing is lost.
  task automatic test_random();
    int press_at[N];
    int lost0, guard;
    clear_all();
    lost0 = lost_cnt;
    for (int k = 0; k < N; k++) press_at[k] = 0;
    for (int slot = 0; slot < 61; slot++) begin
      guard = 0;
      while ((edge_n + 1) % TICK != 5 && guard < 2 * TICK) begin
        step();
        guard++;
      end
      for (int k = 0; k < N; k++) begin
        if (slot == 60 || $urandom_range(0, 2) == 0) begin
          if (!key_pressed[k] && slot != 60) begin
            key_pressed[k] = 1'b1;
            press_at[k] = edge_n + 1;
          end else if (key_pressed[k]) begin
            key_pressed[k] = 1'b0;
            model_hold(k, press_at[k], edge_n + 1);
          end
        end
      end
      step();
    end
    repeat (12) step();
    for (int k = 0; k < N; k++) begin
      int ec[$];
      int ee[$];
      int oc[$];
      int oe[$];
      foreach (exp_code[i]) if (exp_code[i] / 4 == k) begin ec.push_back(exp_code[i]); ee.push_back(exp_edge[i]); end
      foreach (obs_code[i]) if (obs_code[i] / 4 == k) begin oc.push_back(obs_code[i]); oe.push_back(obs_edge[i]); end
      checks++;
      if (oc.size() != ec.size()) begin
        errors++;
        $display("FAIL rnd_count_key%0d: got %0d events expected %0d", k, oc.size(), ec.size());
      end
      for (int i = 0; i < ec.size() && i < oc.size(); i++) begin
        checks++;
        if (oc[i] != ec[i] || oe[i] - ee[i] < 1 || oe[i] - ee[i] > N) begin
          errors++;
          $display("FAIL rnd_key%0d_ev%0d: code=%0d edge=%0d expected code=%0d edge in %0d..%0d", k, i, oc[i], oe[i], ec[i], ee[i] + 1, ee[i] + N);
        end
      end
    end
    checks++;
    if (lost_cnt - lost0 != 0) begin errors++; $display("FAIL rnd_lost: got %0d pulses expected 0", lost_cnt - lost0); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_press_release();
    test_long_repeat();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
